mko_access_sched: RTL
=====================

Name: mko_access_sched

Overview:
Sequences all host-side bus cycles to the five 1895VA2T MKO channels. Requesters (the local-bus bridge, the interrupt poller, and any others) share one physical MKO data/address bus. A round-robin arbiter grants one requester at a time. A cycle FSM then drives the per-channel SELECT_N/STRBD_N, the shared RDWR_N, address and data, and waits for READYD_N with a timeout. The block sits between the local-bus register decode and the MKO pins, next to the MKO RDAT/reset register block.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
WB_DATA_WIDTH, 16, MKO data bus width
MKO_ADDR_WIDTH, 12, MKO register address width
SETUP_CYC, 2, CLK_32 cycles of SELECT_N/address/data setup before STRBD_N falls (1..15)
HOLD_CYC, 2, CLK_32 cycles of bus hold/turnaround after strobes rise (1..15)
TIMEOUT_CYC, 64, max CLK_32 cycles in STROBE waiting for READYD_N (2..255)

Ports:
CLK_32  in  1  sole clock
RESET_N  in  1  asynchronous, active-low reset
REQ  in  NUM_REQ  request per requester; held until that requester's ACK
REQ_CH  in  3*NUM_REQ  target channel 0..4 per requester, packed
REQ_WE  in  NUM_REQ  1 = write, 0 = read
REQ_ADR  in  MKO_ADDR_WIDTH*NUM_REQ  MKO register address, packed
REQ_DAT  in  WB_DATA_WIDTH*NUM_REQ  write data, packed
CH_RES_N  in  5  channel reset state from the MKO register block (0 = channel held in reset)
GNT  out  NUM_REQ  one-hot grant, high for the whole transaction
ACK  out  NUM_REQ  one-cycle completion pulse to the granted requester
ERR  out  1  valid with ACK: timeout, channel >4, or channel in reset
RDATA  out  WB_DATA_WIDTH  read data, valid with ACK, held until next ACK
MKO_SELECT_N  out  5  per-channel select
MKO_STRBD_N  out  5  per-channel data strobe
MKO_RDWR_N  out  1  1 = read, 0 = write
MKO_ADR  out  MKO_ADDR_WIDTH  shared address
MKO_DAT_O  out  WB_DATA_WIDTH  shared write data
MKO_DAT_OE  out  1  write-data drive enable
MKO_DAT_I  in  WB_DATA_WIDTH  shared read data
MKO_READYD_N  in  5  per-channel ready, asynchronous to CLK_32

Behaviour:
- Reset values (async on RESET_N low; takes effect immediately, even mid-transaction): GNT=0, ACK=0, ERR=0, RDATA=0, SELECT_N=STRBD_N=5'b11111, RDWR_N=1, MKO_ADR=0, MKO_DAT_O=0, DAT_OE=0, state IDLE, rr pointer = NUM_REQ-1 (requester 0 has first priority). No ACK is issued for an aborted cycle.
- All outputs are registered. MKO_READYD_N passes through a 2-flop synchronizer per channel.
- States: IDLE, SETUP, STROBE, CAPTURE, RELEASE, ERROR.
- IDLE:
  - If any REQ is high, grant the first requester above the rr pointer (wrapping) and latch its ch/we/adr/dat.
  - If ch>4 or CH_RES_N[ch]=0, go to ERROR. Otherwise go to SETUP: SELECT_N[ch]=0, RDWR_N=~we, MKO_ADR/DAT_O driven, DAT_OE=we.
  - Set the rr pointer to the granted index.
- SETUP: hold for SETUP_CYC cycles, then go to STROBE with STRBD_N[ch]=0.
- STROBE:
  - Count cycles.
  - If synced READYD_N[ch]=0, go to CAPTURE.
  - If the count reaches TIMEOUT_CYC first, go to CAPTURE with the error flag set.
  - READYD on a non-selected channel is ignored.
- CAPTURE (1 cycle):
  - On a read without error, RDATA<=MKO_DAT_I; on a read with error, RDATA<=16'hFFFF; RDATA is unchanged on writes.
  - STRBD_N and SELECT_N go to all ones.
- RELEASE:
  - Hold RDWR_N and MKO_ADR for HOLD_CYC cycles. DAT_OE=0 from the first RELEASE cycle.
  - On the last cycle, pulse ACK[g]=1 and ERR=flag; then GNT=0 and go to IDLE.
- ERROR (1 cycle): no pin activity; ACK[g]=1, ERR=1, RDATA unchanged; go to IDLE.
- Requester rule: REQ may stay high on the ACK cycle. It is sampled again only in IDLE, at least 1 cycle after ACK. A requester that keeps REQ high therefore issues a back-to-back new transaction.
- Only one channel's SELECT_N/STRBD_N is ever low; at most one requester's GNT is ever high.
- Requests arriving mid-transaction wait; there is no preemption.
- Transaction latency from REQ sampled in IDLE to ACK: SETUP_CYC + n_wait + 1 + HOLD_CYC + 1 cycles, where n_wait ≥ 3 (the 2-flop synchronizer plus the detect cycle).

Decomposition:
- Shared package mko_pkg: state encoding, channel count MKO_NUM_CH=5, CH_MAX=3'd4, and the timeout read value 16'hFFFF.
- Sub-module mko_rr_arbiter: a parameterised round-robin arbiter with a one-hot grant and a pointer update on accept.

Test Plan:
- Reset, then req0 writes ch2, adr 0x01A, dat 0x1234, with READYD_N[2] low 2 cycles after STRBD_N[2] falls -> SELECT_N=5'b11011, RDWR_N=0, DAT_OE=1, ACK[0] pulse, ERR=0, single-channel strobe only.
- req1 reads ch4 with MKO_DAT_I=0xBEEF -> RDWR_N=1, DAT_OE=0 throughout, RDATA=0xBEEF at ACK[1].
- req0 and req1 request simultaneously and continuously -> grants alternate 0,1,0,1; no GNT overlap; strobes idle for ≥HOLD_CYC between cycles.
- Read of ch1 with READYD_N held high -> STRBD_N low for exactly TIMEOUT_CYC=64 cycles, then ACK with ERR=1 and RDATA=0xFFFF.
- REQ_CH=5, or ch3 with CH_RES_N[3]=0 -> no pin toggles, ACK+ERR exactly 2 cycles after REQ.
- RESET_N asserted during STROBE -> all SELECT_N/STRBD_N=1 immediately (async), GNT=0, no ACK; the next request completes normally.

Source files
------------

// File: rtl/mko_pkg.sv
// mko_pkg: shared definitions for the MKO host-side access scheduler.
//   - cycle FSM state encoding
//   - MKO channel count, highest valid channel number
//   - read value returned on a timed-out read
//   - ch_onehot(): channel number to per-channel one-hot (zero when out of range)
package mko_pkg;

    localparam int unsigned MKO_NUM_CH     = 5;
    localparam logic [2:0]  CH_MAX         = 3'd4;
    localparam logic [15:0] RD_TIMEOUT_VAL = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RELEASE = 3'd4,
        ST_ERROR   = 3'd5
    } mko_state_e;

    // One-hot channel mask; an out-of-range channel yields all zeros.
    function automatic logic [MKO_NUM_CH-1:0] ch_onehot(input logic [2:0] ch);
        logic [MKO_NUM_CH-1:0] oh;
        oh = '0;
        if (ch <= CH_MAX) begin
            oh[ch] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/mko_rr_arbiter.sv
// mko_rr_arbiter: round-robin arbiter with one-hot grant.
//   CLK_32, RESET_N : clock, async active-low reset
//   req             : request vector
//   accept          : grant taken this cycle; pointer moves to the granted index
//   gnt_c           : combinational one-hot grant (first requester above pointer)
//   gnt_idx_c       : combinational index of gnt_c
module mko_rr_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               CLK_32,
    input  logic               RESET_N,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   gnt_idx_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Search starts one above the last granted index, wrapping around.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt_idx_c = cand;
            end
        end
        gnt_c[gnt_idx_c] = found;
    end

    // Reset pointer to the last index so requester 0 wins first.
    always_ff @(posedge CLK_32 or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (accept) begin
            ptr_q <= gnt_idx_c;
        end
    end

endmodule

// File: rtl/mko_access_sched.sv
// mko_access_sched: arbitrates host requesters onto the shared MKO bus and
// runs one select/strobe/ready cycle per grant with a READYD_N timeout.
//   CLK_32, RESET_N          : clock, async active-low reset
//   REQ/REQ_CH/REQ_WE/REQ_ADR/REQ_DAT : per-requester request and payload (packed)
//   CH_RES_N                 : per-channel reset state (0 = channel in reset)
//   GNT, ACK, ERR, RDATA     : requester-side grant, completion, error, read data
//   MKO_*                    : channel pins; MKO_READYD_N is asynchronous
module mko_access_sched
    import mko_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned WB_DATA_WIDTH  = 16,
    parameter int unsigned MKO_ADDR_WIDTH = 12,
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned HOLD_CYC       = 2,
    parameter int unsigned TIMEOUT_CYC    = 64
) (
    input  logic                                CLK_32,
    input  logic                                RESET_N,
    input  logic [NUM_REQ-1:0]                  REQ,
    input  logic [3*NUM_REQ-1:0]                REQ_CH,
    input  logic [NUM_REQ-1:0]                  REQ_WE,
    input  logic [MKO_ADDR_WIDTH*NUM_REQ-1:0]   REQ_ADR,
    input  logic [WB_DATA_WIDTH*NUM_REQ-1:0]    REQ_DAT,
    input  logic [MKO_NUM_CH-1:0]               CH_RES_N,
    output logic [NUM_REQ-1:0]                  GNT,
    output logic [NUM_REQ-1:0]                  ACK,
    output logic                                ERR,
    output logic [WB_DATA_WIDTH-1:0]            RDATA,
    output logic [MKO_NUM_CH-1:0]               MKO_SELECT_N,
    output logic [MKO_NUM_CH-1:0]               MKO_STRBD_N,
    output logic                                MKO_RDWR_N,
    output logic [MKO_ADDR_WIDTH-1:0]           MKO_ADR,
    output logic [WB_DATA_WIDTH-1:0]            MKO_DAT_O,
    output logic                                MKO_DAT_OE,
    input  logic [WB_DATA_WIDTH-1:0]            MKO_DAT_I,
    input  logic [MKO_NUM_CH-1:0]               MKO_READYD_N
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    mko_state_e state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      flag_q, flag_d;
    logic                      we_q, we_d;
    logic [MKO_NUM_CH-1:0]     ch_oh_q, ch_oh_d;
    logic [WB_DATA_WIDTH-1:0]  cap_q, cap_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d, ack_q, ack_d;
    logic                      err_q, err_d;
    logic [WB_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [MKO_NUM_CH-1:0]     sel_n_q, sel_n_d, strb_n_q, strb_n_d;
    logic                      rdwr_n_q, rdwr_n_d, dat_oe_q, dat_oe_d;
    logic [MKO_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0]  dat_o_q, dat_o_d;
    logic [MKO_NUM_CH-1:0]     rdy_s1_q, rdy_s2_q;

    logic [NUM_REQ-1:0]        arb_gnt_c;
    logic [IDX_W-1:0]          arb_idx_c;
    logic                      arb_accept_c;
    logic [2:0]                req_ch_c;
    logic                      req_we_c, req_bad_c, rdy_hit_c;
    logic [MKO_ADDR_WIDTH-1:0] req_adr_c;
    logic [WB_DATA_WIDTH-1:0]  req_dat_c;

    mko_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .CLK_32    (CLK_32),
        .RESET_N   (RESET_N),
        .req       (REQ),
        .accept    (arb_accept_c),
        .gnt_c     (arb_gnt_c),
        .gnt_idx_c (arb_idx_c)
    );

    // Payload mux from the one-hot arbiter grant.
    always_comb begin
        req_ch_c  = '0;
        req_we_c  = 1'b0;
        req_adr_c = '0;
        req_dat_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt_c[i]) begin
                req_ch_c  = REQ_CH[i*3 +: 3];
                req_we_c  = REQ_WE[i];
                req_adr_c = REQ_ADR[i*MKO_ADDR_WIDTH +: MKO_ADDR_WIDTH];
                req_dat_c = REQ_DAT[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
            end
        end
        req_bad_c = (req_ch_c > CH_MAX) || (|(ch_onehot(req_ch_c) & ~CH_RES_N));
        rdy_hit_c = |(ch_oh_q & ~rdy_s2_q);
    end

    // Cycle FSM: next state and next register values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flag_d       = flag_q;
        we_d         = we_q;
        ch_oh_d      = ch_oh_q;
        cap_d        = cap_q;
        gnt_d        = gnt_q;
        ack_d        = '0;
        err_d        = 1'b0;
        rdata_d      = rdata_q;
        sel_n_d      = sel_n_q;
        strb_n_d     = strb_n_q;
        rdwr_n_d     = rdwr_n_q;
        adr_d        = adr_q;
        dat_o_d      = dat_o_q;
        dat_oe_d     = dat_oe_q;
        arb_accept_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The ACK cycle is skipped so a requester's stale REQ is not re-sampled.
                if (ack_q == '0 && REQ != '0) begin
                    arb_accept_c = 1'b1;
                    gnt_d        = arb_gnt_c;
                    cnt_d        = '0;
                    flag_d       = 1'b0;
                    we_d         = req_we_c;
                    ch_oh_d      = ch_onehot(req_ch_c);
                    if (req_bad_c) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d  = ST_SETUP;
                        sel_n_d  = ~ch_onehot(req_ch_c);
                        rdwr_n_d = ~req_we_c;
                        adr_d    = req_adr_c;
                        dat_oe_d = req_we_c;
                        if (req_we_c) begin
                            dat_o_d = req_dat_c;
                        end
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d  = ST_STROBE;
                    cnt_d    = '0;
                    strb_n_d = ~ch_oh_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STROBE: begin
                // Data is sampled while the strobe is still low.
                if (rdy_hit_c || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d  = ST_CAPTURE;
                    cnt_d    = '0;
                    flag_d   = !rdy_hit_c;
                    cap_d    = rdy_hit_c ? MKO_DAT_I : WB_DATA_WIDTH'(RD_TIMEOUT_VAL);
                    sel_n_d  = '1;
                    strb_n_d = '1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_d  = ST_RELEASE;
                dat_oe_d = 1'b0;
            end
            ST_RELEASE: begin
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    state_d  = ST_IDLE;
                    ack_d    = gnt_q;
                    err_d    = flag_q;
                    gnt_d    = '0;
                    rdwr_n_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = cap_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
                ack_d   = gnt_q;
                err_d   = 1'b1;
                gnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, output registers and READYD_N synchronizer.
    always_ff @(posedge CLK_32 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            we_q     <= 1'b0;
            ch_oh_q  <= '0;
            cap_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            sel_n_q  <= '1;
            strb_n_q <= '1;
            rdwr_n_q <= 1'b1;
            adr_q    <= '0;
            dat_o_q  <= '0;
            dat_oe_q <= 1'b0;
            rdy_s1_q <= '1;
            rdy_s2_q <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            we_q     <= we_d;
            ch_oh_q  <= ch_oh_d;
            cap_q    <= cap_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            sel_n_q  <= sel_n_d;
            strb_n_q <= strb_n_d;
            rdwr_n_q <= rdwr_n_d;
            adr_q    <= adr_d;
            dat_o_q  <= dat_o_d;
            dat_oe_q <= dat_oe_d;
            rdy_s1_q <= MKO_READYD_N;
            rdy_s2_q <= rdy_s1_q;
        end
    end

    assign GNT          = gnt_q;
    assign ACK          = ack_q;
    assign ERR          = err_q;
    assign RDATA        = rdata_q;
    assign MKO_SELECT_N = sel_n_q;
    assign MKO_STRBD_N  = strb_n_q;
    assign MKO_RDWR_N   = rdwr_n_q;
    assign MKO_ADR      = adr_q;
    assign MKO_DAT_O    = dat_o_q;
    assign MKO_DAT_OE   = dat_oe_q;

endmodule
